// File: rtl/rf_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
package rf_pkg;

  localparam int RF_XLEN      = 32;
  localparam int RF_REG_COUNT = 32;
  localparam int RF_AW        = 5;

  localparam logic [RF_AW-1:0] RF_ZERO = 5'd0;

  // One register-file write: destination register and value.
  typedef struct packed {
    logic [RF_AW-1:0]   addr;
    logic [RF_XLEN-1:0] data;
  } rf_wr_t;

endpackage

// File: rtl/rf_wr_fifo.sv
// Synchronous DEPTH-entry FIFO of rf_wr_t used to buffer auxiliary writes.
// Pointers carry one extra MSB so full and empty are distinguishable.
// The caller guarantees no push when full and no pop when empty.
module rf_wr_fifo
  import rf_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push_i,
  input  rf_wr_t      push_data_i,
  input  logic        pop_i,
  output rf_wr_t      head_o,
  output logic        full_o,
  output logic        empty_o,
  output logic [AW:0] count_o
);

  rf_wr_t      mem_q [DEPTH];
  logic [AW:0] wptr_q, wptr_d;
  logic [AW:0] rptr_q, rptr_d;

  // Advance the pointers on push/pop.
  always_comb begin
    // NOTE: combinational blocks use blocking '=' and assign every output a default first, so no latch is inferred.
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push_i) wptr_d = wptr_q + 1'b1;
    if (pop_i)  rptr_d = rptr_q + 1'b1;
  end

  // Pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking '<=' so every flop samples pre-edge values.
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage write.
  // NOTE: the storage array is deliberately not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wptr_q[AW-1:0]] <= push_data_i;
  end

  assign head_o  = mem_q[rptr_q[AW-1:0]];
  assign count_o = wptr_q - rptr_q;
  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

endmodule

// File: rtl/rf_wr_arbiter.sv
// Write-port arbiter for the 32-entry register file. The pipeline writeback
// has priority and is never delayed on its path; auxiliary writes are queued
// and drained into idle write-port cycles. pend_mask flags registers with a
// queued auxiliary write.
// Build option: define RF_ARB_STARVE_EN to add the starvation counter that
// briefly stalls writeback so a long-waiting auxiliary write can retire.
module rf_wr_arbiter
  import rf_pkg::*;
#(
  parameter int XLEN       = RF_XLEN,
  parameter int REG_COUNT  = RF_REG_COUNT,
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8,
  localparam int CW        = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wb_we,
  input  logic [RF_AW-1:0]     wb_waddr,
  input  logic [XLEN-1:0]      wb_wdata,
  output logic                 wb_stall,
  input  logic                 aux_valid,
  output logic                 aux_ready,
  input  logic [RF_AW-1:0]     aux_waddr,
  input  logic [XLEN-1:0]      aux_wdata,
  output logic                 rf_we,
  output logic [RF_AW-1:0]     rf_waddr,
  output logic [XLEN-1:0]      rf_wdata,
  output logic [REG_COUNT-1:0] pend_mask,
  output logic [CW-1:0]        fifo_cnt
);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_chk
    $error("rf_wr_arbiter: DEPTH must be a power of 2 and at least 2");
  end
  if ((STARVE_MAX < 1) || (STARVE_MAX > 255)) begin : g_starve_chk
    $error("rf_wr_arbiter: STARVE_MAX must be in 1..255");
  end
  if (XLEN != RF_XLEN) begin : g_xlen_chk
    $error("rf_wr_arbiter: XLEN must match rf_pkg::RF_XLEN");
  end

  rf_wr_t               head;
  rf_wr_t               push_data;
  logic                 fifo_full, fifo_empty;
  logic                 wb_real;
  logic                 aux_hs, push, pop;
  logic                 grant_fifo;
  logic                 stall_act;
  logic [REG_COUNT-1:0] pend_mask_q, pend_mask_d;

  // A write to r0 is architecturally void and does not claim the port.
  assign wb_real = wb_we && (wb_waddr != RF_ZERO);

  // No bypass: a full FIFO refuses even if it pops this cycle. A register
  // already pending is refused so each register has at most one queued write.
  assign aux_ready = rst_n && !fifo_full && !pend_mask_q[aux_waddr];
  assign aux_hs    = aux_valid && aux_ready;
  assign push      = aux_hs && (aux_waddr != RF_ZERO);
  assign push_data = '{addr: aux_waddr, data: aux_wdata};

  // FIFO head wins when stalling for starvation or when the pipeline is idle.
  assign grant_fifo = !fifo_empty && (stall_act || !wb_real);
  assign pop        = grant_fifo;

  assign rf_we    = rst_n && (grant_fifo || wb_real);
  assign rf_waddr = grant_fifo ? head.addr : wb_waddr;
  assign rf_wdata = grant_fifo ? head.data : wb_wdata;
  assign wb_stall = rst_n && stall_act && wb_real;

  rf_wr_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (pop),
    .head_o      (head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_cnt)
  );

  // Pending mask: clear the retiring register, then mark the newly queued one.
  always_comb begin
    pend_mask_d = pend_mask_q;
    if (pop)  pend_mask_d[head.addr] = 1'b0;
    if (push) pend_mask_d[aux_waddr] = 1'b1;
  end

  // Pending mask register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend_mask_q <= '0;
    else        pend_mask_q <= pend_mask_d;
  end

  assign pend_mask = pend_mask_q;

`ifdef RF_ARB_STARVE_EN
  logic [7:0] starve_cnt_q, starve_cnt_d;
  logic       stall_act_q, stall_act_d;
  logic       losing;

  // The queue is waiting while the pipeline takes the port.
  assign losing = !fifo_empty && !grant_fifo;

  // Starvation count and the stall flag that forces one FIFO grant.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    stall_act_d  = stall_act_q;
    if (pop || fifo_empty) begin
      starve_cnt_d = 8'd0;
    end else if (losing && (starve_cnt_q != 8'hFF)) begin
      starve_cnt_d = starve_cnt_q + 8'd1;
    end
    if (pop) begin
      stall_act_d = 1'b0;
    end else if (losing && (starve_cnt_q == 8'(STARVE_MAX - 1))) begin
      stall_act_d = 1'b1;
    end
  end

  // Starvation state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_q <= 8'd0;
      stall_act_q  <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      stall_act_q  <= stall_act_d;
    end
  end

  assign stall_act = stall_act_q;
`else
  assign stall_act = 1'b0;
`endif

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Self-checking bench for rf_wr_arbiter. A scoreboard queue holds every
// accepted auxiliary write; each rf write that is not the pipeline's is
// popped and compared. Directed checks cover priority, timing and boundaries.
module tb_rf_wr_arbiter;
  import rf_pkg::*;

  localparam int XLEN       = 32;
  localparam int REG_COUNT  = 32;
  localparam int DEPTH      = 4;
  localparam int STARVE_MAX = 8;
  localparam int CW         = $clog2(DEPTH) + 1;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 wb_we = 1'b0;
  logic [4:0]           wb_waddr = '0;
  logic [XLEN-1:0]      wb_wdata = '0;
  logic                 wb_stall;
  logic                 aux_valid = 1'b0;
  logic                 aux_ready;
  logic [4:0]           aux_waddr = '0;
  logic [XLEN-1:0]      aux_wdata = '0;
  logic                 rf_we;
  logic [4:0]           rf_waddr;
  logic [XLEN-1:0]      rf_wdata;
  logic [REG_COUNT-1:0] pend_mask;
  logic [CW-1:0]        fifo_cnt;

  int     n_tests = 0;
  int     n_fail  = 0;
  rf_wr_t exp_q[$];

  always #5 clk = ~clk;

  rf_wr_arbiter #(
    .XLEN(XLEN), .REG_COUNT(REG_COUNT), .DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata), .wb_stall(wb_stall),
    .aux_valid(aux_valid), .aux_ready(aux_ready), .aux_waddr(aux_waddr), .aux_wdata(aux_wdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .pend_mask(pend_mask), .fifo_cnt(fifo_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic av, input logic [4:0] aa, input logic [31:0] ad);
    wb_we = we; wb_waddr = wa; wb_wdata = wd;
    aux_valid = av; aux_waddr = aa; aux_wdata = ad;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: retire pipeline or queued writes, then record new accepts.
  always @(negedge clk) begin : sb
    rf_wr_t e;
    if (rst_n) begin
      if (wb_we && (wb_waddr != 5'd0) && !wb_stall) begin
        check("sb_wb_we", rf_we, 1);
        check("sb_wb_addr", rf_waddr, wb_waddr);
        check("sb_wb_data", rf_wdata, wb_wdata);
      end else if (exp_q.size() != 0) begin
        check("sb_drain_we", rf_we, 1);
        if (rf_we) begin
          e = exp_q.pop_front();
          check("sb_drain_addr", rf_waddr, e.addr);
          check("sb_drain_data", rf_wdata, e.data);
        end
      end else begin
        check("sb_idle_we", rf_we, 0);
      end
      if (aux_valid && aux_ready && (aux_waddr != 5'd0))
        exp_q.push_back('{addr: aux_waddr, data: aux_wdata});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state with live requests on the inputs.
    drive(1, 3, 32'h33, 1, 4, 32'h44);
    #2;
    check("rst_rf_we", rf_we, 0);
    check("rst_wb_stall", wb_stall, 0);
    check("rst_aux_ready", aux_ready, 0);
    check("rst_fifo_cnt", fifo_cnt, 0);
    check("rst_pend", pend_mask, 0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    next();

    // Idle pipeline: aux write appears the next cycle, pending for one cycle.
    drive(0, 0, 0, 1, 5, 32'h11);
    smp(); check("t1_ready", aux_ready, 1); check("t1_we0", rf_we, 0); next();
    drive(0, 0, 0, 0, 0, 0);
    smp();
    check("t1_we", rf_we, 1); check("t1_addr", rf_waddr, 5); check("t1_data", rf_wdata, 32'h11);
    check("t1_pend", pend_mask, 32'h20); check("t1_cnt", fifo_cnt, 1);
    next();
    smp(); check("t1_pend_clr", pend_mask, 0); check("t1_idle", rf_we, 0); next();

    // Pipeline priority: r7 only reaches the port once wb_we drops.
    drive(1, 1, 32'hA1, 1, 7, 32'h77);
    smp(); check("t2_ready", aux_ready, 1); check("t2_a", rf_waddr, 1); next();
    drive(1, 2, 32'hA2, 0, 0, 0);
    smp(); check("t2_b", rf_waddr, 2); check("t2_cnt", fifo_cnt, 1); check("t2_pend", pend_mask, 32'h80); next();
    drive(1, 3, 32'hA3, 0, 0, 0);
    smp(); check("t2_c", rf_waddr, 3); next();
    drive(0, 0, 0, 0, 0, 0);
    smp(); check("t2_d_addr", rf_waddr, 7); check("t2_d_data", rf_wdata, 32'h77); next();
    smp(); check("t2_e_we", rf_we, 0); check("t2_e_cnt", fifo_cnt, 0); next();

    // Backpressure: fill the FIFO behind a busy pipeline.
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 32'hB0 + i, 1, 5'(10 + i), 32'hC0 + i);
      smp(); check("t3_fill_ready", aux_ready, 1); next();
    end
    drive(1, 1, 32'hB4, 1, 14, 32'hC4);
    smp(); check("t3_full_ready", aux_ready, 0); check("t3_full_cnt", fifo_cnt, 4); next();
    drive(0, 0, 0, 1, 14, 32'hC4);
    smp(); check("t3_fullpop_ready", aux_ready, 0); check("t3_pop10", rf_waddr, 10); next();
    drive(0, 0, 0, 1, 12, 32'hCC);
    smp(); check("t3_pend_ready", aux_ready, 0); check("t3_pend_cnt", fifo_cnt, 3); next();
    drive(0, 0, 0, 1, 14, 32'hC4);
    smp(); check("t3_free_ready", aux_ready, 1); check("t3_free_cnt", fifo_cnt, 2); next();
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin smp(); next(); end
    smp(); check("t3_drained_cnt", fifo_cnt, 0); check("t3_drained_pend", pend_mask, 0); next();

    // Zero register: wb to r0 yields to the FIFO; aux to r0 is swallowed.
    drive(1, 1, 32'hD1, 1, 20, 32'h20);
    smp(); check("t4_ready", aux_ready, 1); next();
    drive(1, 0, 32'hDEAD, 0, 0, 0);
    smp(); check("t4_r0_we", rf_we, 1); check("t4_r0_addr", rf_waddr, 20); check("t4_r0_data", rf_wdata, 32'h20); next();
    drive(0, 0, 0, 1, 0, 32'h55);
    smp(); check("t4_aux0_ready", aux_ready, 1); check("t4_aux0_cnt", fifo_cnt, 0); next();
    drive(0, 0, 0, 0, 0, 0);
    smp(); check("t4_aux0_we", rf_we, 0); check("t4_aux0_cnt2", fifo_cnt, 0); check("t4_aux0_pend", pend_mask, 0); next();

    // Starvation: continuous pipeline writes with one queued entry.
    drive(1, 1, 32'hE0, 1, 9, 32'h99);
    smp(); check("t5_ready", aux_ready, 1); next();
    for (int i = 1; i <= 8; i++) begin
      drive(1, 1, 32'hE0 + i, 0, 0, 0);
      smp(); check("t5_nostall", wb_stall, 0); check("t5_wb_wins", rf_waddr, 1); next();
    end
`ifdef RF_ARB_STARVE_EN
    drive(1, 2, 32'hF2, 0, 0, 0);
    smp(); check("t5_stall9", wb_stall, 1); check("t5_head9_addr", rf_waddr, 9); check("t5_head9_data", rf_wdata, 32'h99); next();
    smp(); check("t5_stall10", wb_stall, 0); check("t5_held_addr", rf_waddr, 2); check("t5_held_data", rf_wdata, 32'hF2); next();
`else
    for (int i = 0; i < 4; i++) begin
      drive(1, 2, 32'hF0 + i, 0, 0, 0);
      smp(); check("t5_never_stall", wb_stall, 0); check("t5_still_queued", fifo_cnt, 1); next();
    end
    drive(0, 0, 0, 0, 0, 0);
    smp(); check("t5_idle_drain", rf_waddr, 9); next();
`endif
    drive(0, 0, 0, 0, 0, 0);
    smp(); check("t5_empty", fifo_cnt, 0); next();

    // Reset mid-operation with three entries queued.
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 32'h90 + i, 1, 5'(21 + i), 32'h70 + i);
      next();
    end
    drive(1, 1, 32'h93, 1, 25, 32'h73);
    #1;
    check("t6_pre_cnt", fifo_cnt, 3);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("t6_rf_we", rf_we, 0);
    check("t6_wb_stall", wb_stall, 0);
    check("t6_aux_ready", aux_ready, 0);
    check("t6_pend", pend_mask, 0);
    check("t6_cnt", fifo_cnt, 0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    next();
    smp(); check("t6_post_we", rf_we, 0); check("t6_post_cnt", fifo_cnt, 0); next();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_wr_arbiter.md
# rf_wr_arbiter

Write-port arbiter and scoreboard for the 32-entry register file. It shares the register file's single write port between the pipeline writeback stage and a long-latency auxiliary unit (mul/div, late load return). The pipeline writeback has priority and cannot be back-pressured. Auxiliary writes are buffered in a small FIFO and drained into idle write-port cycles. A per-register pending mask lets issue logic detect outstanding auxiliary writes.

## Interface
- XLEN, 32, data width
- REG_COUNT, 32, number of architectural registers; the address width is 5 bits
- DEPTH, 4, auxiliary FIFO entries; must be a power of 2, at least 2
- STARVE_MAX, 8, consecutive lost cycles before the starvation stall fires; range 1..255
- clk  input  1  clock; rising edge
- rst_n  input  1  asynchronous, active-low reset
- wb_we  input  1  pipeline writeback write request
- wb_waddr  input  5  pipeline write address
- wb_wdata  input  XLEN  pipeline write data
- wb_stall  output  1  pipeline must freeze its WB stage and re-present the same write next cycle
- aux_valid  input  1  auxiliary write offered
- aux_ready  output  1  auxiliary write accepted this cycle
- aux_waddr  input  5  auxiliary write address
- aux_wdata  input  XLEN  auxiliary write data
- rf_we  output  1  to register file write enable
- rf_waddr  output  5  to register file write address
- rf_wdata  output  XLEN  to register file write data
- pend_mask  output  REG_COUNT  bit i set while a write to register i is queued
- fifo_cnt  output  $clog2(DEPTH)+1  current FIFO occupancy

## Operation
- Clock and reset: one clock; reset is asynchronous and active-low.
- Pipeline request: a request is "real" only when wb_we=1 and wb_waddr≠0. A write to address 0 does not occupy the port.
- Auxiliary accept:
  - aux_ready = !full && !pend_mask[aux_waddr].
  - aux_ready may depend combinationally on aux_waddr.
  - A handshake to address 0 is accepted and discarded: no enqueue, no pending bit.
- Enqueue: on handshake, push {aux_waddr, aux_wdata} and set pend_mask[aux_waddr].
- Grant, evaluated each cycle:
  - If stall_act=1 and the FIFO is non-empty, the FIFO head is granted.
  - Otherwise, a real pipeline request is granted.
  - Otherwise, if the FIFO is non-empty, the FIFO head is granted.
  - Otherwise, rf_we=0.
- On a FIFO grant:
  - Drive rf_* from the head.
  - Pop the head at the clock edge and clear pend_mask[head.addr].
- Pipeline write to a pending address: it is still granted. Avoiding WAW hazards on such addresses is the issue logic's job, using pend_mask.
- Ordering: auxiliary writes retire strictly in FIFO order.

## Timing
- The rf_* outputs are combinational from the wb_* inputs and the FIFO head; there are no added cycles on the pipeline path.
- Auxiliary latency: a write accepted at edge N can reach rf_* at the earliest in the cycle after edge N.
- Accept-to-pending: pend_mask is set in the cycle after the accept edge.
- Same address pushed and popped on one edge: only possible when the popped entry's address differs, because of the pend_mask gating; clear and set both apply.
- Full FIFO with a pop in the same cycle: aux_ready stays 0 (no bypass).
- Starvation counter starve_cnt (8 bits):
  - Increments each cycle the FIFO is non-empty and the pipeline wins.
  - Clears on any FIFO pop or when the FIFO is empty.
  - stall_act is a register. It is set at the edge where starve_cnt reaches STARVE_MAX-1 while still losing.
  - stall_act clears at the edge of the next FIFO pop.
- wb_stall = stall_act && real pipeline request (combinational).
- Reset values:
  - FIFO empty, pend_mask=0, fifo_cnt=0, starve_cnt=0, stall_act=0.
  - While rst_n=0, rf_we, wb_stall and aux_ready are forced to 0.
- Reset mid-operation: queued auxiliary writes are lost. Re-issuing them is the auxiliary unit's responsibility.

## Configuration
- RF_ARB_STARVE_EN defined: the starvation counter, stall_act and the wb_stall behaviour above are present.
- RF_ARB_STARVE_EN undefined:
  - No counter or stall register; wb_stall is tied to 0.
  - The pipeline always wins, and the FIFO drains only in idle cycles.

## Structure
- Package rf_pkg holds:
  - XLEN and REG_COUNT defaults, and RF_AW=5.
  - Typedef rf_wr_t, a packed struct {addr, data}.
  - Constant RF_ZERO=5'd0.
- Sub-module rf_wr_fifo:
  - Synchronous DEPTH-entry FIFO of rf_wr_t.
  - Wrap-around read/write pointers with an extra MSB for full/empty.
  - Exposes head, push, pop, full, empty and count.
- The arbiter holds the grant mux, pend_mask and the starvation logic.

## Test plan
- Idle pipeline:
  - Stimulus: push aux {r5, 0x11}.
  - Required: rf_we=1, r5, 0x11 in the next cycle; pend_mask[5] is set for exactly one cycle.
- Pipeline priority:
  - Stimulus: wb_we=1 every cycle to r1..r3 (STARVE_EN off), FIFO holding r7, then wb_we=0.
  - Required: r7 appears on rf_* only in the first cycle with wb_we=0.
- Backpressure:
  - Stimulus: pipeline busy, push 4 entries to distinct registers.
  - Required: aux_ready=0 on the 5th offer, fifo_cnt=4.
  - Stimulus: an offer to an already-pending register.
  - Required: aux_ready=0 even when the FIFO is not full.
- Zero register:
  - Stimulus: wb_we to r0 while the FIFO is non-empty.
  - Required: the FIFO head is granted.
  - Stimulus: an aux write to r0.
  - Required: the handshake completes, fifo_cnt is unchanged, rf_we stays 0.
- Starvation (STARVE_EN, STARVE_MAX=8):
  - Stimulus: continuous pipeline writes with one queued entry.
  - Required: wb_stall=1 in cycle 9, the FIFO head is written that cycle, wb_stall=0 in cycle 10, and the held pipeline write completes.
- Reset:
  - Stimulus: assert rst_n=0 with 3 entries queued.
  - Required: outputs are immediately 0, pend_mask=0, fifo_cnt=0.
